// File: rtl/ram_stream_ctrl_if.sv
// Command, upstream-stream and downstream-stream signals of ram_stream_ctrl.
// master drives commands/upstream words and takes downstream words; slave is the controller.
interface ram_stream_ctrl_if #(
  parameter int ADDRESS_SIZE = 4,
  parameter int WORD_SIZE    = 32
);
  logic                    start_load;
  logic                    start_dump;
  logic [ADDRESS_SIZE-1:0] base_addr;
  logic [ADDRESS_SIZE:0]   count;
  logic                    in_valid;
  logic [WORD_SIZE-1:0]    in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic [WORD_SIZE-1:0]    out_data;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start_load, start_dump, base_addr, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start_load, start_dump, base_addr, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/ram_stream_ctrl.sv
// Port-1 sequencer for the ODE state RAM: LOAD streams words into consecutive addresses, DUMP streams them out.
// Optional LOAD_CHECKSUM_EN adds load_sum, the running sum of words written during LOAD.
module ram_stream_ctrl #(
  parameter int ADDRESS_SIZE = 4,
  parameter int WORD_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_stream_ctrl_if.slave        bus,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  inout  wire  [WORD_SIZE-1:0]    ram_data
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]    load_sum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, DUMP, DRAIN} state_t;

  localparam logic [ADDRESS_SIZE-1:0] PTR_ONE = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE:0]   REM_ONE = (ADDRESS_SIZE+1)'(1);

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] ptr;
  logic [ADDRESS_SIZE:0]   rem;
  logic                    fetch;

  // Gating with rst keeps a reset cycle from committing a partial word to the RAM.
  assign bus.in_ready = (state == LOAD) && !rst;
  assign bus.busy     = (state != IDLE);
  assign ram_we       = bus.in_ready && bus.in_valid;
  assign ram_addr     = ptr;
  assign ram_data     = ram_we ? bus.in_data : {WORD_SIZE{1'bz}};
  assign fetch        = (state == DUMP) && (!bus.out_valid || bus.out_ready) && (rem != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      rem           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.done      <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      load_sum      <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_load || bus.start_dump) begin
            ptr <= bus.base_addr;
            rem <= bus.count;
            if (bus.count == '0)
              bus.done <= 1'b1;
            else if (bus.start_load)
              state <= LOAD;
            else
              state <= DUMP;
`ifdef LOAD_CHECKSUM_EN
            if (bus.start_load)
              load_sum <= '0;
`endif
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            ptr <= ptr + PTR_ONE;
            rem <= rem - REM_ONE;
`ifdef LOAD_CHECKSUM_EN
            load_sum <= load_sum + bus.in_data;
`endif
            if (rem == REM_ONE) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        DUMP: begin
          // Asynchronous RAM read: ram_data already reflects mem[ptr] this cycle.
          if (fetch) begin
            bus.out_data  <= ram_data;
            bus.out_valid <= 1'b1;
            ptr           <= ptr + PTR_ONE;
            rem           <= rem - REM_ONE;
            if (rem == REM_ONE)
              state <= DRAIN;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
            bus.done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
